// File: rtl/mux_scan_nx1_if.sv
// ============================================================================
// mux_scan_nx1_if : channel bus, select/mode/enable controls and scan outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface mux_scan_nx1_if #(
  parameter int N = 8,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] a;
  logic [SW-1:0]  s;
  logic           mode;
  logic           en;
  logic [W-1:0]   y;
  logic [SW-1:0]  ch;
  logic           y_valid;
  logic           wrap;

  modport master (
    output a, s, mode, en,
    input  y, ch, y_valid, wrap
  );

  modport slave (
    input  a, s, mode, en,
    output y, ch, y_valid, wrap
  );
endinterface

`default_nettype wire

// File: rtl/mux_scan_nx1.sv
// ============================================================================
// mux_scan_nx1 : registered N-to-1 mux with manual select or dwell-timed scan
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_scan_nx1 #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mux_scan_nx1_if.slave    bus
);
  localparam int SW  = $clog2(N);
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SW-1:0]  c_last_ch    = SW'(N - 1);
  localparam logic [DCW-1:0] c_dwell_last = DCW'(DWELL - 1);

  logic [W-1:0]   r_y;
  logic [SW-1:0]  r_ch;
  logic           r_valid;
  logic           r_wrap;
  logic [DCW-1:0] r_dwell;

  logic [W-1:0]   w_man_data;
  logic [W-1:0]   w_auto_data;
  logic           w_ch_in_range;

  // Indices at or beyond N select nothing and yield zero.
  function automatic logic [W-1:0] sel_chan(input logic [N*W-1:0] data,
                                            input logic [SW-1:0]  idx);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SW'(k)) r = data[k*W +: W];
    end
    return r;
  endfunction

  always_comb begin
    w_man_data    = sel_chan(bus.a, bus.s);
    w_auto_data   = sel_chan(bus.a, r_ch);
    w_ch_in_range = (r_ch <= c_last_ch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_dwell <= '0;
    end else begin
      r_valid <= bus.en;
      r_wrap  <= 1'b0;
      if (bus.en) begin
        if (!bus.mode) begin
          r_ch    <= bus.s;
          r_y     <= w_man_data;
          r_dwell <= '0;
        end else begin
          r_y <= w_auto_data;
          // An out-of-range pointer left by manual mode restarts the scan at once.
          if (!w_ch_in_range) begin
            r_ch    <= '0;
            r_wrap  <= 1'b1;
            r_dwell <= '0;
          end else if (r_dwell == c_dwell_last) begin
            r_dwell <= '0;
            if (r_ch == c_last_ch) begin
              r_ch   <= '0;
              r_wrap <= 1'b1;
            end else begin
              r_ch <= r_ch + 1'b1;
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
      end
    end
  end

  assign bus.y       = r_y;
  assign bus.ch      = r_ch;
  assign bus.y_valid = r_valid;
  assign bus.wrap    = r_wrap;

endmodule

`default_nettype wire
